banco_reg: RTL and testbench
============================

Name: banco_reg

Overview:
- 32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
- Sits directly downstream of the register-destination mux: its write address is that mux's 5-bit output.
- Supplies the A/B operand registers through two read ports; writes once per clock when the control unit asserts reg_write.
- $zero is hardwired; $sp takes a fixed stack-top value on reset.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- SP_RESET, 227, value loaded into register 29 ($sp) on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- reg_write  input  1  write enable from the control unit.
- read_reg1  input  ADDR_W  read port 1 index (inst[25:21]).
- read_reg2  input  ADDR_W  read port 2 index (inst[20:16]).
- write_reg  input  ADDR_W  write index (register-destination mux output: rt, rd or 31).
- write_data  input  DATA_W  write data (memory-to-register mux output).
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.

Behaviour:
- Storage: 32 registers of DATA_W bits.
- Reset (synchronous, reset=1 at a rising edge):
  - all registers <= 0, except reg 29 <= SP_RESET.
  - reset has priority over reg_write; a write presented in the reset cycle is discarded.
- Reset mid-operation: the state after the edge is exactly the reset state, regardless of pending writes.
- Write (reset=0, reg_write=1 at a rising edge): reg[write_reg] <= write_data. Single write port, one write per cycle.
- Register 0:
  - writes with write_reg=0 are ignored; reg 0 always reads 0.
  - the storage element for reg 0 may be omitted.
- Reads:
  - combinational (asynchronous): read_data1 = reg[read_reg1], read_data2 = reg[read_reg2].
  - zero added latency; reads reflect state as of the last edge.
- Output values after reset: read_data = 0 for any index except 29, which returns SP_RESET.
- Same-cycle read/write of the same index (feature off): read returns the OLD value; the new value is visible from the cycle after the edge.
- Both read ports may address the same register; both return identical data.
- reg_write=0: no state change; write_reg/write_data are don't-care.
- write_reg=31 (jal path) is an ordinary write; no special casing.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: BANCO_REG_BYPASS_EN
- Defined: write-through forwarding.
  - If reg_write=1, write_reg!=0 and read_regN==write_reg in the same cycle, read_dataN = write_data combinationally (also during reset=0 only).
  - Lets a later single-cycle or pipelined datapath read a value in its write cycle.
- Undefined: no forwarding; old-value semantics as above. Default build leaves it undefined (multicycle control does not need it).

Decomposition:
- Package banco_reg_pkg:
  - REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31.
  - SP_RESET_VAL=32'd227.
  - typedef of the DATA_W word and ADDR_W register index.
  - Shared with the register-destination mux (its constant 31 becomes REG_RA) and the control unit.
- No sub-module is natural. Storage array, write logic and read muxing stay in one module; the bypass is a small per-port mux inside the same file.

Test Plan:
- Reset: hold reset=1 one edge with reg_write=1, write_reg=5, write_data=32'hFFFF_FFFF -> read reg5=0, reg29=227, reg31=0, reg0=0.
- Basic write/read: write reg8=32'h1234_5678, then reg31=32'hDEAD_BEEF (jal) -> read_data1(8)=32'h1234_5678, read_data2(31)=32'hDEAD_BEEF next cycle.
- Zero register: reg_write=1, write_reg=0, write_data=32'hA5A5_A5A5 -> read reg0 = 0 on both ports.
- Write disabled: reg_write=0, write_reg=10, write_data=7 -> reg10 remains at its prior value (0 after reset).
- Same-cycle read/write: reg12 holds 3; write reg12=9 while read_reg1=12 -> read_data1=3 before the edge and 9 after; with BANCO_REG_BYPASS_EN, 9 in the same cycle.
- Reset mid-stream: write reg29=100, then reset for one edge -> reg29=227; the write attempted in the reset cycle is lost.

Source files
------------

// File: rtl/banco_reg_pkg.sv
// Shared constants and types for the MIPS register file, reg-dest mux and control.
package banco_reg_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_SP       = 5'd29;
    localparam logic [4:0]  REG_RA       = 5'd31;
    localparam logic [31:0] SP_RESET_VAL = 32'd227;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/banco_reg.sv
// 32x32 register file, two async read ports, one write port, $zero hardwired.
// Define BANCO_REG_BYPASS_EN to forward write_data to a matching read port.
module banco_reg
    import banco_reg_pkg::*;
#(
    parameter int                DATA_W   = banco_reg_pkg::DATA_W,
    parameter int                ADDR_W   = banco_reg_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;

    assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Index 0 is forced to zero on read as well as on write.
    always_comb begin
        read_data1 = (read_reg1 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[read_reg1];
        read_data2 = (read_reg2 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[read_reg2];
`ifdef BANCO_REG_BYPASS_EN
        if (!reset && wr_en && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (!reset && wr_en && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_banco_reg.sv
// Directed self-checking bench for banco_reg.
module tb_banco_reg;
    import banco_reg_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     reg_write;
    reg_idx_t read_reg1;
    reg_idx_t read_reg2;
    reg_idx_t write_reg;
    word_t    write_data;
    word_t    read_data1;
    word_t    read_data2;

    int n_checks = 0;
    int n_fails  = 0;

    banco_reg dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input reg_idx_t a, input reg_idx_t b);
        read_reg1 = a;
        read_reg2 = b;
        #1;
    endtask

    task automatic wr(input reg_idx_t idx, input word_t d);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'hFFFF_FFFF;
        read_reg1  = '0;
        read_reg2  = '0;
        tick();
        reset     = 1'b0;
        reg_write = 1'b0;

        rd(5'd5, REG_SP);
        check("rst_r5", read_data1, 32'd0);
        check("rst_sp", read_data2, 32'd227);
        rd(REG_RA, REG_ZERO);
        check("rst_r31", read_data1, 32'd0);
        check("rst_r0", read_data2, 32'd0);

        wr(5'd8, 32'h1234_5678);
        wr(REG_RA, 32'hDEAD_BEEF);
        rd(5'd8, REG_RA);
        check("wr_r8", read_data1, 32'h1234_5678);
        check("wr_r31", read_data2, 32'hDEAD_BEEF);

        rd(REG_RA, REG_RA);
        check("dual_p1", read_data1, 32'hDEAD_BEEF);
        check("dual_p2", read_data2, 32'hDEAD_BEEF);

        wr(REG_ZERO, 32'hA5A5_A5A5);
        rd(REG_ZERO, REG_ZERO);
        check("zero_p1", read_data1, 32'd0);
        check("zero_p2", read_data2, 32'd0);

        reg_write  = 1'b0;
        write_reg  = 5'd10;
        write_data = 32'd7;
        tick();
        rd(5'd10, 5'd8);
        check("nowr_r10", read_data1, 32'd0);
        check("nowr_r8", read_data2, 32'h1234_5678);

        wr(5'd12, 32'd3);
        read_reg1  = 5'd12;
        read_reg2  = 5'd8;
        reg_write  = 1'b1;
        write_reg  = 5'd12;
        write_data = 32'd9;
        #1;
`ifdef BANCO_REG_BYPASS_EN
        check("same_pre", read_data1, 32'd9);
`else
        check("same_pre", read_data1, 32'd3);
`endif
        check("same_oth", read_data2, 32'h1234_5678);
        tick();
        reg_write = 1'b0;
        rd(5'd12, 5'd12);
        check("same_post", read_data1, 32'd9);

        wr(REG_SP, 32'd100);
        wr(5'd7, 32'h0BAD_F00D);
        rd(REG_SP, 5'd7);
        check("pre_rst_sp", read_data1, 32'd100);
        check("pre_rst_r7", read_data2, 32'h0BAD_F00D);

        reset      = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h5555_5555;
        read_reg1  = 5'd7;
        #1;
`ifdef BANCO_REG_BYPASS_EN
        check("rst_nobyp", read_data1, 32'h0BAD_F00D);
`else
        check("rst_nobyp", read_data1, 32'h0BAD_F00D);
`endif
        tick();
        reset     = 1'b0;
        reg_write = 1'b0;
        rd(REG_SP, 5'd7);
        check("mid_rst_sp", read_data1, 32'd227);
        check("mid_rst_r7", read_data2, 32'd0);
        rd(5'd8, REG_RA);
        check("mid_rst_r8", read_data1, 32'd0);
        check("mid_rst_r31", read_data2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
